alu_secuenciador: RTL and testbench

- Registered command front end that owns the 8-bit combinational ALU's input side and result side.
- Accepts operation requests over a valid/ready handshake and drives opcode and operands onto the ALU.
- Waits a fixed settle time, then captures the 16-bit result and returns it with flags over a second valid/ready handshake.
- Detects division and modulo by zero itself; those requests never reach the ALU.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_secuenciador.sv | 146 ++++++++++++++
 tb/tb_alu_secuenciador.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, widths and FSM encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;

    localparam logic [2:0] OpSum = 3'b000;
    localparam logic [2:0] OpRes = 3'b001;
    localparam logic [2:0] OpPro = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpMod = 3'b100;
    localparam logic [2:0] OpAnd = 3'b101;
    localparam logic [2:0] OpOr  = 3'b110;
    localparam logic [2:0] OpXor = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCapture,
        StResp
    } sec_state_e;

    function automatic logic is_div_zero(input logic [2:0] op, input logic [DATA_W-1:0] b);
        return ((op == OpDiv) || (op == OpMod)) && (b == '0);
    endfunction

    function automatic logic has_carry(input logic [2:0] op);
        return (op == OpSum) || (op == OpRes);
    endfunction

endpackage

// File: rtl/alu_secuenciador.sv
// Registered command front end for the external combinational ALU.
// Optional operand chaining enabled by defining ALU_SEC_ENCADENA_EN.
module alu_secuenciador
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_SEC_ENCADENA_EN
    input  logic              cmd_encadena,
`endif
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_dato0,
    output logic [DATA_W-1:0] alu_dato1,
    input  logic [RES_W-1:0]  alu_resultado,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_resultado,
    output logic              rsp_acarreo,
    output logic              rsp_cero,
    output logic              rsp_error,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [3:0] LatLast = 4'(ALU_LAT - 1);

    sec_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        alu_op_q;
    logic [DATA_W-1:0] alu_dato0_q, alu_dato1_q;
    logic [RES_W-1:0]  rsp_resultado_q;
    logic              rsp_acarreo_q, rsp_cero_q, rsp_error_q;
    logic [CNT_W-1:0]  op_count_q;
    logic              accept, div_zero, rsp_hs;
    logic [DATA_W-1:0] oper_a;

`ifdef ALU_SEC_ENCADENA_EN
    logic [DATA_W-1:0] ultimo_q;

    assign oper_a = cmd_encadena ? ultimo_q : cmd_a;

    // Error responses carry no result, so they must not disturb the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ultimo_q <= '0;
        end else if (rsp_hs && !rsp_error_q) begin
            ultimo_q <= rsp_resultado_q[DATA_W-1:0];
        end
    end
`else
    assign oper_a = cmd_a;
`endif

    assign div_zero = is_div_zero(cmd_op, cmd_b);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        rsp_hs    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = div_zero ? StResp : StDrive;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LatLast) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            alu_op_q        <= '0;
            alu_dato0_q     <= '0;
            alu_dato1_q     <= '0;
            rsp_resultado_q <= '0;
            rsp_acarreo_q   <= 1'b0;
            rsp_cero_q      <= 1'b0;
            rsp_error_q     <= 1'b0;
            op_count_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // A zero divisor is answered locally; the ALU inputs keep the previous command.
            if (accept && div_zero) begin
                rsp_resultado_q <= '0;
                rsp_acarreo_q   <= 1'b0;
                rsp_cero_q      <= 1'b0;
                rsp_error_q     <= 1'b1;
            end else if (accept) begin
                alu_op_q    <= cmd_op;
                alu_dato0_q <= oper_a;
                alu_dato1_q <= cmd_b;
            end
            if (state_q == StCapture) begin
                rsp_resultado_q <= alu_resultado;
                rsp_acarreo_q   <= has_carry(alu_op_q) & alu_resultado[DATA_W];
                rsp_cero_q      <= (alu_resultado == '0);
                rsp_error_q     <= 1'b0;
            end
            if (rsp_hs) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign alu_op        = alu_op_q;
    assign alu_dato0     = alu_dato0_q;
    assign alu_dato1     = alu_dato1_q;
    assign rsp_resultado = rsp_resultado_q;
    assign rsp_acarreo   = rsp_acarreo_q;
    assign rsp_cero      = rsp_cero_q;
    assign rsp_error     = rsp_error_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Scoreboard bench for alu_secuenciador with a behavioural ALU attached to its ALU ports.
module tb_alu_secuenciador;
    import alu_pkg::*;

    localparam int unsigned LAT = 1;
    localparam int unsigned CW  = 16;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic        cmd_encadena = 1'b0;
    logic [2:0]  alu_op;
    logic [7:0]  alu_dato0, alu_dato1;
    logic [15:0] alu_resultado;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_resultado;
    logic        rsp_acarreo, rsp_cero, rsp_error;
    logic [CW-1:0] op_count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_count = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_secuenciador #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
`ifdef ALU_SEC_ENCADENA_EN
        .cmd_encadena(cmd_encadena),
`endif
        .alu_op(alu_op),
        .alu_dato0(alu_dato0),
        .alu_dato1(alu_dato1),
        .alu_resultado(alu_resultado),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_resultado(rsp_resultado),
        .rsp_acarreo(rsp_acarreo),
        .rsp_cero(rsp_cero),
        .rsp_error(rsp_error),
        .op_count(op_count)
    );

    // External ALU stand-in.
    always_comb begin
        alu_resultado = '0;
        case (alu_op)
            OpSum: alu_resultado = {8'h00, alu_dato0} + {8'h00, alu_dato1};
            OpRes: alu_resultado = {8'h00, alu_dato0} - {8'h00, alu_dato1};
            OpPro: alu_resultado = {8'h00, alu_dato0} * {8'h00, alu_dato1};
            OpDiv: alu_resultado = (alu_dato1 == 0) ? 16'h0 : {8'h00, alu_dato0 / alu_dato1};
            OpMod: alu_resultado = (alu_dato1 == 0) ? 16'h0 : {8'h00, alu_dato0 % alu_dato1};
            OpAnd: alu_resultado = {8'h00, alu_dato0 & alu_dato1};
            OpOr:  alu_resultado = {8'h00, alu_dato0 | alu_dato1};
            default: alu_resultado = {8'h00, alu_dato0 ^ alu_dato1};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got 0x%0h, expected none", rsp_resultado);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_resultado", 32'(rsp_resultado), 32'(e.res));
                check("rsp_acarreo", 32'(rsp_acarreo), 32'(e.c));
                check("rsp_cero", 32'(rsp_cero), 32'(e.z));
                check("rsp_error", 32'(rsp_error), 32'(e.e));
            end
        end
    end

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic enc, input int stall, input logic [15:0] res,
                           input logic c, input logic z, input logic e);
        int k;
        int guard;
        exp_t x;
        x.res = res; x.c = c; x.z = z; x.e = e;
        sb.push_back(x);
        @(posedge clk); #1;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_encadena = enc;
        cmd_valid = 1'b1;
        rsp_ready = (stall == 0);
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 1;
        @(negedge clk);
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), e ? 32'd1 : 32'(LAT + 2));
        if (stall > 0) begin
            // A competing command is offered while the response is stalled.
            cmd_valid = 1'b1; cmd_op = OpSum; cmd_a = 8'd1; cmd_b = 8'd1;
            for (int i = 0; i < stall; i++) begin
                check("stall_res", 32'(rsp_resultado), 32'(res));
                check("stall_valid", 32'(rsp_valid), 32'd1);
                check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
                @(posedge clk);
            end
            #1;
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        exp_count++;
        check("op_count", 32'(op_count), 32'(exp_count));
        check("rsp_valid_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", {16'h0, 5'h0, alu_op, alu_dato0}, 32'd0);
        check("rst_dato1", 32'(alu_dato1), 32'd0);
        check("rst_resultado", 32'(rsp_resultado), 32'd0);
        check("rst_flags", {29'h0, rsp_acarreo, rsp_cero, rsp_error}, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(OpSum, 8'd200, 8'd100, 1'b0, 0, 16'h012C, 1'b1, 1'b0, 1'b0);
        run_cmd(OpRes, 8'd5,   8'd5,   1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_cmd(OpRes, 8'd3,   8'd5,   1'b0, 0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run_cmd(OpDiv, 8'd7,   8'd0,   1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("div0_alu_op", 32'(alu_op), 32'(OpRes));
        check("div0_alu_dato0", 32'(alu_dato0), 32'd3);
        check("div0_alu_dato1", 32'(alu_dato1), 32'd5);
        run_cmd(OpPro, 8'd255, 8'd255, 1'b0, 3, 16'hFE01, 1'b0, 1'b0, 1'b0);
        run_cmd(OpAnd, 8'hF0,  8'h3C,  1'b0, 0, 16'h0030, 1'b0, 1'b0, 1'b0);
        run_cmd(OpOr,  8'hF0,  8'h0F,  1'b0, 0, 16'h00FF, 1'b0, 1'b0, 1'b0);
        run_cmd(OpXor, 8'hAA,  8'hAA,  1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_cmd(OpDiv, 8'd200, 8'd7,   1'b0, 0, 16'h001C, 1'b0, 1'b0, 1'b0);
        run_cmd(OpMod, 8'd200, 8'd7,   1'b0, 0, 16'h0004, 1'b0, 1'b0, 1'b0);
        run_cmd(OpSum, 8'd255, 8'd1,   1'b0, 0, 16'h0100, 1'b1, 1'b0, 1'b0);
        run_cmd(OpMod, 8'd0,   8'd0,   1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Reset while MOD 9%4 is in DRIVE: no response may follow.
        @(posedge clk); #1;
        cmd_op = OpMod; cmd_a = 8'd9; cmd_b = 8'd4; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(OpSum, 8'd1, 8'd1, 1'b0, 0, 16'h0002, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEC_ENCADENA_EN
        run_cmd(OpSum, 8'd10, 8'd5, 1'b0, 0, 16'h000F, 1'b0, 1'b0, 1'b0);
        run_cmd(OpDiv, 8'd7,  8'd0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_cmd(OpSum, 8'd99, 8'd3, 1'b1, 0, 16'h0012, 1'b0, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
